// File: rtl/div_pkg.sv
// Shared constants, state encoding and helpers for the restoring divider.
// Optional feature macro: SIGNED_DIV_EN (two's complement operands).
package div_pkg;

  localparam int DIV_W  = 5;
  localparam int ITER_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Quotient reported when the divisor is zero
  localparam logic [DIV_W-1:0] DZ_QUOT = 5'b11111;

`ifdef SIGNED_DIV_EN
  // Iteration 0 converts operands to magnitudes, iterations 1..5 divide
  localparam logic [ITER_W-1:0] LAST_ITER = 3'd5;
`else
  // Iterations 0..4 divide
  localparam logic [ITER_W-1:0] LAST_ITER = 3'd4;
`endif

  // Two's complement negation of an operand-width value
  function automatic logic [DIV_W-1:0] negate(input logic [DIV_W-1:0] v);
    return ~v + 1'b1;
  endfunction

endpackage

// File: rtl/restoring_div_mod_if.sv
// Request/result handshake bundle for the restoring divider.
// The divider sits on the slave side, the requester on the master side.
interface restoring_div_mod_if;
  import div_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [DIV_W-1:0] X;
  logic [DIV_W-1:0] Y;
  logic             out_valid;
  logic             out_ready;
  logic [DIV_W-1:0] Q;
  logic [DIV_W-1:0] R;
  logic             DZ;
  logic             OV;

  modport master (
    output in_valid, X, Y, out_ready,
    input  in_ready, out_valid, Q, R, DZ, OV
  );

  modport slave (
    input  in_valid, X, Y, out_ready,
    output in_ready, out_valid, Q, R, DZ, OV
  );

endinterface

// File: rtl/div_step_mod.sv
// One combinational restoring-division step: shift the {remainder, dividend}
// pair left, trial-subtract the divisor with a ripple of full-adder cells,
// and keep or restore the remainder depending on the borrow.
module div_step_mod
  import div_pkg::*;
(
  input  logic [DIV_W-1:0] rem_i,
  input  logic [DIV_W-1:0] dvd_i,
  input  logic [DIV_W-1:0] dvs_i,
  output logic [DIV_W-1:0] rem_o,
  output logic [DIV_W-1:0] dvd_o
);

  logic [DIV_W:0]   shifted;
  logic [DIV_W:0]   subB;
  logic [DIV_W-1:0] trial;
  logic [DIV_W+1:0] carry;
  logic             qBit;

  assign shifted  = {rem_i, dvd_i[DIV_W-1]};
  assign subB     = ~{1'b0, dvs_i};
  assign carry[0] = 1'b1;

  // Full-adder chain computing shifted + ~divisor + 1; the top sum bit is
  // never needed because a kept result always fits in the remainder width
  for (genvar i = 0; i <= DIV_W; i++) begin : gFa
    assign carry[i+1] = (shifted[i] & subB[i]) | (shifted[i] & carry[i]) |
                        (subB[i] & carry[i]);
    if (i < DIV_W) begin : gSum
      assign trial[i] = shifted[i] ^ subB[i] ^ carry[i];
    end
  end

  // Carry out set means no borrow, so the trial difference is non-negative
  assign qBit  = carry[DIV_W+1];
  assign rem_o = qBit ? trial : shifted[DIV_W-1:0];
  assign dvd_o = {dvd_i[DIV_W-2:0], qBit};

endmodule

// File: rtl/restoring_div_mod.sv
// Sequential 5-bit restoring divider with valid/ready handshakes on both
// sides. One step per cycle through a single div_step_mod instance.
// Optional feature macro: SIGNED_DIV_EN (two's complement, truncating).
module restoring_div_mod
  import div_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  restoring_div_mod_if.slave  bus
);

  state_t            state_q;
  logic [ITER_W-1:0] cnt_q;
  logic [DIV_W-1:0]  rem_q;
  logic [DIV_W-1:0]  dvd_q;
  logic [DIV_W-1:0]  dvs_q;
  logic [DIV_W-1:0]  q_q;
  logic [DIV_W-1:0]  r_q;
  logic              dz_q;
  logic              inReady_q;
  logic              outValid_q;
  logic [DIV_W-1:0]  rem_d;
  logic [DIV_W-1:0]  dvd_d;
`ifdef SIGNED_DIV_EN
  logic              ov_q;
  logic              xNeg_q;
  logic              yNeg_q;
`endif

  div_step_mod uStep (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dvs_i (dvs_q),
    .rem_o (rem_d),
    .dvd_o (dvd_d)
  );

  // Control FSM and datapath registers; all outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      q_q        <= '0;
      r_q        <= '0;
      dz_q       <= 1'b0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
`ifdef SIGNED_DIV_EN
      ov_q       <= 1'b0;
      xNeg_q     <= 1'b0;
      yNeg_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && inReady_q) begin
            state_q   <= CALC;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= bus.X;
            dvs_q     <= bus.Y;
            dz_q      <= 1'b0;
            inReady_q <= 1'b0;
`ifdef SIGNED_DIV_EN
            xNeg_q    <= bus.X[DIV_W-1];
            yNeg_q    <= bus.Y[DIV_W-1];
            ov_q      <= (bus.X == {1'b1, {(DIV_W-1){1'b0}}}) && (bus.Y == '1);
`endif
          end
        end
        CALC: begin
          if (dvs_q == '0) begin
            state_q    <= DONE;
            q_q        <= DZ_QUOT;
            r_q        <= dvd_q;
            dz_q       <= 1'b1;
            outValid_q <= 1'b1;
`ifdef SIGNED_DIV_EN
            ov_q       <= 1'b0;
          end else if (cnt_q == '0) begin
            dvd_q <= xNeg_q ? negate(dvd_q) : dvd_q;
            dvs_q <= yNeg_q ? negate(dvs_q) : dvs_q;
            cnt_q <= cnt_q + 1'b1;
`endif
          end else begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
              state_q    <= DONE;
              outValid_q <= 1'b1;
`ifdef SIGNED_DIV_EN
              q_q <= (xNeg_q ^ yNeg_q) ? negate(dvd_d) : dvd_d;
              r_q <= xNeg_q ? negate(rem_d) : rem_d;
`else
              q_q <= dvd_d;
              r_q <= rem_d;
`endif
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.Q         = q_q;
  assign bus.R         = r_q;
  assign bus.DZ        = dz_q;
`ifdef SIGNED_DIV_EN
  assign bus.OV        = ov_q;
`else
  assign bus.OV        = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_div_mod.sv
// Directed self-checking bench for restoring_div_mod.
// Honours SIGNED_DIV_EN to select the signed or unsigned vector set.
module tb_restoring_div_mod;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   lat;
  logic seen;

  restoring_div_mod_if bus ();

  restoring_div_mod dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present one request, let it be accepted, and measure cycles to out_valid.
  // keepValid leaves in_valid high with altered operands during CALC.
  task automatic applyStimulus(input logic [4:0] x, input logic [4:0] y,
                               input bit keepValid, output int cycles);
    bus.X        = x;
    bus.Y        = y;
    bus.in_valid = 1'b1;
    tick();
    checkOutput("acceptReady", bus.in_ready, 0);
    if (keepValid) begin
      bus.X = ~x;
      bus.Y = y + 5'd1;
    end else begin
      bus.in_valid = 1'b0;
    end
    cycles = 0;
    while (!bus.out_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checkOutput("consumeReady", bus.in_ready, 1);
    checkOutput("consumeValid", bus.out_valid, 0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.X         = '0;
    bus.Y         = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rstReady", bus.in_ready, 1);
    checkOutput("rstValid", bus.out_valid, 0);
    checkOutput("rstQ", bus.Q, 0);
    checkOutput("rstR", bus.R, 0);
    checkOutput("rstDZ", bus.DZ, 0);
    checkOutput("rstOV", bus.OV, 0);

`ifdef SIGNED_DIV_EN
    applyStimulus(5'b10011, 5'd4, 1'b0, lat);
    checkOutput("s13Lat", lat, 6);
    checkOutput("s13Q", bus.Q, 5'b11101);
    checkOutput("s13R", bus.R, 5'b11111);
    checkOutput("s13OV", bus.OV, 0);
    consume();

    applyStimulus(5'b10000, 5'b11111, 1'b0, lat);
    checkOutput("ovLat", lat, 6);
    checkOutput("ovQ", bus.Q, 5'b10000);
    checkOutput("ovR", bus.R, 0);
    checkOutput("ovOV", bus.OV, 1);
    consume();

    applyStimulus(5'd7, 5'd0, 1'b0, lat);
    checkOutput("sdzLat", lat, 1);
    checkOutput("sdzQ", bus.Q, 31);
    checkOutput("sdzR", bus.R, 7);
    checkOutput("sdzDZ", bus.DZ, 1);
    consume();
`else
    applyStimulus(5'd23, 5'd5, 1'b0, lat);
    checkOutput("d23Lat", lat, 5);
    checkOutput("d23Q", bus.Q, 4);
    checkOutput("d23R", bus.R, 3);
    checkOutput("d23DZ", bus.DZ, 0);
    checkOutput("d23OV", bus.OV, 0);
    consume();

    applyStimulus(5'd31, 5'd1, 1'b0, lat);
    checkOutput("d31Q", bus.Q, 31);
    checkOutput("d31R", bus.R, 0);
    consume();

    applyStimulus(5'd3, 5'd7, 1'b0, lat);
    checkOutput("d3Q", bus.Q, 0);
    checkOutput("d3R", bus.R, 3);
    consume();

    applyStimulus(5'd7, 5'd0, 1'b0, lat);
    checkOutput("dzLat", lat, 1);
    checkOutput("dzQ", bus.Q, 31);
    checkOutput("dzR", bus.R, 7);
    checkOutput("dzDZ", bus.DZ, 1);
    consume();

    // Second request held during CALC, then a stalled consumer
    applyStimulus(5'd20, 5'd6, 1'b1, lat);
    checkOutput("holdLat", lat, 5);
    checkOutput("holdQ", bus.Q, 3);
    checkOutput("holdR", bus.R, 2);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("stallValid", bus.out_valid, 1);
      checkOutput("stallReady", bus.in_ready, 0);
      checkOutput("stallQ", bus.Q, 3);
      checkOutput("stallR", bus.R, 2);
    end
    consume();

    // Reset during the third CALC cycle abandons the computation
    bus.X        = 5'd25;
    bus.Y        = 5'd4;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midRstReady", bus.in_ready, 1);
    checkOutput("midRstValid", bus.out_valid, 0);
    checkOutput("midRstQ", bus.Q, 0);
    checkOutput("midRstR", bus.R, 0);
    checkOutput("midRstDZ", bus.DZ, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen = seen | bus.out_valid;
    end
    checkOutput("midRstNoOut", seen, 0);

    applyStimulus(5'd10, 5'd3, 1'b0, lat);
    checkOutput("d10Lat", lat, 5);
    checkOutput("d10Q", bus.Q, 3);
    checkOutput("d10R", bus.R, 1);
    consume();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
